// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and select encodings
// for the multi-cycle RV32I controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR,
    S_JALRWB, S_UPPER, S_ERR, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1,
    ALU_AND  = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLT = 4'd5,
    ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL  = 4'd8, ALU_SRA = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_FN  = 2'b10
  } alu_op_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic op_legal(
    input logic [6:0] op,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD:  ok = !(f3 == 3'b011 || f3[2:1] == 2'b11);
      OP_STORE: ok = (f3 < 3'b011);
      OP_BR:    ok = (f3[2:1] != 2'b01);
      OP_R, OP_I, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared instruction/data
// memory request handshake.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (
    output MemReq, MemWrite, AdrSrc,
    input  MemReady
  );

  modport slave (
    input  MemReq, MemWrite, AdrSrc,
    output MemReady
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps ALUOp/Funct3/Funct7b5/Op5
// to the ALUControl code.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output alu_ctrl_t   alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_BR: begin
        case (funct3[2:1])
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_SUB;
        endcase
      end
      ALUOP_FN: begin
        case (funct3)
          3'b000: alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle FSM sequencer with memory
// wait timeout. Define MC_ILLEGAL_TRAP_EN to trap illegal instructions.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            Op,
  input  logic [2:0]            Funct3,
  input  logic                  Funct7b5,
  input  logic                  Zero,
  input  logic                  ALUR0,
  multicycle_controller_if.master mem,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALUCTRL_W-1:0]  ALUControl,
  output logic [2:0]            Load,
  output logic [1:0]            Store,
  output logic                  MemErr
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic                  Illegal
`endif
);

  localparam int CW = (MEM_TIMEOUT == 0) ? 8 :
                      (MEM_TIMEOUT == 1) ? 1 :
                      $clog2(MEM_TIMEOUT + 1);

  state_t         state, state_n;
  logic [CW-1:0]  wait_cnt;
  alu_op_t        alu_op;
  alu_ctrl_t      alu_ctrl;
  logic           req, timeout, taken, bad_state_sel;
  state_t         bad_state;

  mc_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (Funct3),
    .funct7b5 (Funct7b5),
    .op5      (Op[5]),
    .alu_ctrl (alu_ctrl)
  );

  assign ALUControl = ALUCTRL_W'(alu_ctrl);
  assign req = (state == S_FETCH) || (state == S_MEMREAD) ||
               (state == S_MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && req &&
                   (wait_cnt == CW'(MEM_TIMEOUT));
  assign taken = (Funct3[2] ? ALUR0 : Zero) ^ Funct3[0];
  assign bad_state_sel = !op_legal(Op, Funct3);

`ifdef MC_ILLEGAL_TRAP_EN
  assign bad_state = S_TRAP;
  assign Illegal   = (state == S_TRAP);
`else
  assign bad_state = S_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || mem.MemReady)
        wait_cnt <= '0;
      else if (req && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    mem.MemReq   = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ImmSrc       = IMM_I;
    alu_op       = ALUOP_ADD;
    Load         = 3'b000;
    Store        = 2'b00;
    MemErr       = 1'b0;
    case (state)
      S_FETCH: begin
        mem.MemReq = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURES;
        if (mem.MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        // JAL needs its own offset in ALUOut; all others precompute a branch target
        ImmSrc  = (Op == OP_JAL) ? IMM_J : IMM_B;
        if (bad_state_sel) begin
          state_n = bad_state;
        end else begin
          case (Op)
            OP_LOAD, OP_STORE: state_n = S_MEMADR;
            OP_R:              state_n = S_EXECR;
            OP_I:              state_n = S_EXECI;
            OP_BR:             state_n = S_BRANCH;
            OP_JAL:            state_n = S_JAL;
            OP_JALR:           state_n = S_JALR;
            OP_LUI, OP_AUIPC:  state_n = S_UPPER;
            default:           state_n = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = Op[5] ? IMM_S : IMM_I;
        state_n = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem.MemReq = 1'b1;
        mem.AdrSrc = 1'b1;
        if (mem.MemReady) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        Load      = Funct3;
        RegWrite  = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem.MemReq   = 1'b1;
        mem.MemWrite = 1'b1;
        mem.AdrSrc   = 1'b1;
        Store        = Funct3[1:0];
        if (mem.MemReady) state_n = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FN;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FN;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_BR;
        PCWrite = taken;
        state_n = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_n = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
        state_n   = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        RegWrite  = 1'b1;
        state_n   = S_FETCH;
      end
      S_UPPER: begin
        ALUSrcA = Op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        state_n = S_ALUWB;
      end
      S_ERR:   MemErr = 1'b1;
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
    // a stalled request past the limit overrides everything
    if (timeout) begin
      state_n      = S_ERR;
      mem.MemReq   = 1'b0;
      mem.MemWrite = 1'b0;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemErr       = 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed vectors for the
// multi-cycle controller, MEM_TIMEOUT=4.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Op = OP_R;
  logic [2:0] Funct3 = 3'b000;
  logic       Funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       ALUR0 = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemErr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, Store;
  logic [2:0] ImmSrc, Load;
  logic [3:0] ALUControl;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  int total = 0;
  int bad = 0;
  int r_lat, r_pcw, r_regw, r_early, r_ld, r_st, r_ac, r_sa;

  multicycle_controller_if mif();

  always #5 clk = ~clk;

  multicycle_controller #(
    .ALUCTRL_W   (4),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .Zero       (Zero),
    .ALUR0      (ALUR0),
    .mem        (mif),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Load       (Load),
    .Store      (Store),
    .MemErr     (MemErr)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .Illegal    (Illegal)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // runs one instruction from FETCH until the next FETCH begins
  task automatic run(input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic r0,
                     input int wn);
    int  w;
    int  irw_c;
    bit  prev_f;
    bit  is_f;
    Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z; ALUR0 = r0;
    r_lat = -1; r_pcw = 0; r_regw = 0; r_early = 0;
    r_ld = 99; r_st = 99; r_ac = 99; r_sa = 99;
    w = 0; irw_c = -10; prev_f = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mif.MemReady = (w >= wn);
      #1;
      is_f = mif.MemReq && !mif.AdrSrc;
      if (c > 0 && is_f && !prev_f) begin
        r_lat = c;
        break;
      end
      prev_f = is_f;
      if (PCWrite) r_pcw++;
      if (RegWrite) r_regw++;
      if (RegWrite && ResultSrc == 2'b01) r_ld = int'(Load);
      if (mif.MemWrite && mif.MemReady) r_st = int'(Store);
      if (IRWrite && !mif.MemReady) r_early++;
      if (IRWrite) irw_c = c;
      if (c == irw_c + 2) begin
        r_ac = int'(ALUControl);
        r_sa = int'(ALUSrcA);
      end
      if (mif.MemReq && mif.MemReady) w = 0;
      else if (mif.MemReq) w++;
      tick();
    end
  endtask

  task automatic instr(input string tag, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7,
                       input logic z, input logic r0, input int wn,
                       input int lat, input int pcw, input int regw);
    run(op, f3, f7, z, r0, wn);
    check({tag, ".lat"}, r_lat, lat);
    check({tag, ".pcw"}, r_pcw, pcw);
    check({tag, ".regw"}, r_regw, regw);
  endtask

  initial begin
    mif.MemReady = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rst.memreq", mif.MemReq, 1);
    check("rst.memerr", MemErr, 0);
    check("rst.strobes", {IRWrite, PCWrite, RegWrite, mif.MemWrite}, 0);

    instr("add", OP_R, 3'd0, 1'b0, 0, 0, 0, 4, 1, 1);
    check("add.alu", r_ac, 0);
    instr("sub", OP_R, 3'd0, 1'b1, 0, 0, 0, 4, 1, 1);
    check("sub.alu", r_ac, 1);
    run(OP_R, 3'd3, 1'b0, 0, 0, 0);
    check("sltu.alu", r_ac, 6);
    run(OP_I, 3'd5, 1'b1, 0, 0, 0);
    check("srai.alu", r_ac, 9);
    run(OP_I, 3'd0, 1'b1, 0, 0, 0);
    check("addi.alu", r_ac, 0);

    instr("lw", OP_LOAD, 3'd2, 1'b0, 0, 0, 3, 11, 1, 1);
    check("lw.load", r_ld, 2);
    check("lw.early_irw", r_early, 0);
    instr("lbu", OP_LOAD, 3'd4, 1'b0, 0, 0, 0, 5, 1, 1);
    check("lbu.load", r_ld, 4);
    instr("sw", OP_STORE, 3'd2, 1'b0, 0, 0, 0, 4, 1, 0);
    check("sw.store", r_st, 2);

    instr("beq_t", OP_BR, 3'd0, 1'b0, 1, 0, 0, 3, 2, 0);
    check("beq.alu", r_ac, 1);
    instr("beq_n", OP_BR, 3'd0, 1'b0, 0, 0, 0, 3, 1, 0);
    instr("bne_t", OP_BR, 3'd1, 1'b0, 0, 0, 0, 3, 2, 0);
    instr("bltu_t", OP_BR, 3'd6, 1'b0, 0, 1, 0, 3, 2, 0);
    check("bltu.alu", r_ac, 6);
    instr("bge_n", OP_BR, 3'd5, 1'b0, 0, 1, 0, 3, 1, 0);
    check("bge.alu", r_ac, 5);

    instr("jal", OP_JAL, 3'd0, 1'b0, 0, 0, 0, 4, 2, 1);
    instr("jalr", OP_JALR, 3'd0, 1'b0, 0, 0, 0, 4, 2, 1);
    instr("lui", OP_LUI, 3'd0, 1'b0, 0, 0, 0, 4, 1, 1);
    check("lui.srca", r_sa, 3);
    instr("auipc", OP_AUIPC, 3'd0, 1'b0, 0, 0, 0, 4, 1, 1);
    check("auipc.srca", r_sa, 1);

`ifdef MC_ILLEGAL_TRAP_EN
    Op = 7'b0000000;
    mif.MemReady = 1'b1;
    tick();
    tick();
    check("trap.illegal", Illegal, 1);
    tick();
    tick();
    check("trap.hold", {Illegal, mif.MemReq, RegWrite}, 3'b100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("trap.rst", {Illegal, mif.MemReq}, 2'b01);
`else
    instr("op0", 7'b0000000, 3'd0, 1'b0, 0, 0, 0, 2, 1, 0);
    instr("br010", OP_BR, 3'd2, 1'b0, 1, 0, 0, 2, 1, 0);
`endif

    // reset while a store is waiting on memory
    Op = OP_STORE; Funct3 = 3'd2;
    mif.MemReady = 1'b1;
    tick();
    tick();
    tick();
    mif.MemReady = 1'b0;
    #1;
    check("sw_wait.memwrite", mif.MemWrite, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("sw_rst.fetch", {mif.MemReq, mif.AdrSrc}, 2'b10);
    check("sw_rst.memwrite", mif.MemWrite, 0);
    check("sw_rst.memerr", MemErr, 0);

    // memory never answers the fetch
    for (int i = 1; i <= 4; i++) begin
      mif.MemReady = 1'b0;
      #1;
      check($sformatf("to.wait%0d", i), {mif.MemReq, MemErr}, 2'b10);
      tick();
    end
    check("to.err5", {mif.MemReq, MemErr}, 2'b01);
    mif.MemReady = 1'b1;
    tick();
    check("to.hold", {mif.MemReq, IRWrite, PCWrite, MemErr}, 4'b0001);
    tick();
    check("to.hold2", MemErr, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("to.rst", {mif.MemReq, MemErr}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
